// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_LEN_LO  = 3'd1,
      ST_LEN_HI  = 3'd2,
      ST_DATA_LO = 3'd3,
      ST_DATA_HI = 3'd4,
      ST_CSUM    = 3'd5,
      ST_ERROR   = 3'd6
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/idle_timer.sv
// Reloadable down-counter; expired stays high once the count reaches zero.
module idle_timer #(
   parameter int unsigned TIMEOUT_CYC = 27_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYC);
   localparam logic [W-1:0] ONE    = W'(1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= RELOAD;
      end else if (clear) begin
         cnt <= RELOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - ONE;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/bsram_prog_loader.sv
// Owns the program BSRAM: parses framed UART bytes into 16-bit words, writes
// them from address 0 and keeps the CPU in reset until the checksum matches.
module bsram_prog_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W      = 11,
   parameter int MAX_WORDS   = 2048,
   parameter int TIMEOUT_CYC = 27_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic [ADDR_W-1:0] cpu_adr,
   output logic              mem_ce,
   output logic              mem_wre,
   output logic [ADDR_W-1:0] mem_ad,
   output logic [15:0]       mem_din,
   output logic              cpu_run,
   output logic              load_busy,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [ADDR_W-1:0] AD_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   WL_ONE = (ADDR_W + 1)'(1);

   loader_state_t     state;
   logic [7:0]        len_lo;
   logic [15:0]       len;
   logic [7:0]        lo_byte;
   logic [7:0]        csum;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] wr_ad;
   logic              tmo_expired;

   logic [15:0]     len_word;
   logic            len_ok;
   logic [ADDR_W:0] wl_next;
   logic            last_word;

   assign len_word  = {rx_data, len_lo};
   assign len_ok    = (len_word != 16'd0) && (32'(len_word) <= 32'(MAX_WORDS));
   assign wl_next   = words_loaded + WL_ONE;
   assign last_word = (32'(wl_next) == 32'(len));

   assign cpu_run   = (state == ST_RUN);
   assign load_err  = (state == ST_ERROR);
   assign load_busy = (state != ST_RUN) && (state != ST_ERROR);
   assign mem_ce    = 1'b1;
   // CPU owns the address bus except during the single registered write cycle.
   assign mem_ad    = mem_wre ? wr_ad : cpu_adr;

   idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_idle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (rx_valid | ~load_busy),
      .en      (load_busy),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RUN;
         len_lo       <= 8'd0;
         len          <= 16'd0;
         lo_byte      <= 8'd0;
         csum         <= 8'd0;
         wr_addr      <= '0;
         wr_ad        <= '0;
         words_loaded <= '0;
         mem_wre      <= 1'b0;
         mem_din      <= 16'd0;
      end else begin
         mem_wre <= 1'b0;
         if (load_busy && tmo_expired && !rx_valid) begin
            state <= ST_ERROR;
         end else if (rx_valid) begin
            case (state)
               ST_RUN, ST_ERROR: begin
                  if (rx_data == SYNC_BYTE) begin
                     state        <= ST_LEN_LO;
                     words_loaded <= '0;
                     csum         <= 8'd0;
                     wr_addr      <= '0;
                  end
               end
               ST_LEN_LO: begin
                  len_lo <= rx_data;
                  state  <= ST_LEN_HI;
               end
               ST_LEN_HI: begin
                  len   <= len_word;
                  state <= len_ok ? ST_DATA_LO : ST_ERROR;
               end
               ST_DATA_LO: begin
                  lo_byte <= rx_data;
                  state   <= ST_DATA_HI;
               end
               ST_DATA_HI: begin
                  mem_wre      <= 1'b1;
                  mem_din      <= {rx_data, lo_byte};
                  wr_ad        <= wr_addr;
                  wr_addr      <= wr_addr + AD_ONE;
                  words_loaded <= wl_next;
                  csum         <= csum ^ lo_byte ^ rx_data;
                  state        <= last_word ? ST_CSUM : ST_DATA_LO;
               end
               ST_CSUM: begin
                  state <= (rx_data == csum) ? ST_RUN : ST_ERROR;
               end
               default: state <= ST_RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bsram_prog_loader.sv
// Directed bench for bsram_prog_loader with a short idle timeout.
module tb_bsram_prog_loader;

   localparam int ADDR_W = 11;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic [ADDR_W-1:0] cpu_adr;
   logic              mem_ce;
   logic              mem_wre;
   logic [ADDR_W-1:0] mem_ad;
   logic [15:0]       mem_din;
   logic              cpu_run;
   logic              load_busy;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   int n_vec = 0;
   int n_err = 0;
   int n_wr  = 0;
   int wr_snap;

   logic [15:0] prog [3] = '{16'h00A1, 16'h0078, 16'h0066};
   logic [7:0]  good_csum;

   bsram_prog_loader #(
      .ADDR_W      (ADDR_W),
      .MAX_WORDS   (2048),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .cpu_adr      (cpu_adr),
      .mem_ce       (mem_ce),
      .mem_wre      (mem_wre),
      .mem_ad       (mem_ad),
      .mem_din      (mem_din),
      .cpu_run      (cpu_run),
      .load_busy    (load_busy),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && mem_wre) n_wr <= n_wr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; strobes one byte across the next posedge.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input int idx);
      send_byte(w[7:0]);
      chk("wre_single", 32'(mem_wre), 32'd0);
      send_byte(w[15:8]);
      chk("wr_pulse", 32'(mem_wre), 32'd1);
      chk("wr_addr", 32'(mem_ad), 32'(idx));
      chk("wr_data", 32'(mem_din), 32'(w));
      chk("words_cnt", 32'(words_loaded), 32'(idx + 1));
   endtask

   task automatic send_frame(input int len, input logic [7:0] cs);
      send_byte(8'hA5);
      chk("sync_run_low", 32'(cpu_run), 32'd0);
      chk("sync_busy", 32'(load_busy), 32'd1);
      chk("sync_err_clr", 32'(load_err), 32'd0);
      send_byte(8'(len));
      send_byte(8'(len >> 8));
      for (int i = 0; i < len; i++) send_word(prog[i], i);
      send_byte(cs);
      chk("csum_wre_off", 32'(mem_wre), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      cpu_adr  = 11'h123;
      good_csum = prog[0][7:0] ^ prog[0][15:8] ^ prog[1][7:0] ^ prog[1][15:8]
                ^ prog[2][7:0] ^ prog[2][15:8];
      repeat (3) @(negedge clk);
      chk("rst_cpu_run", 32'(cpu_run), 32'd1);
      chk("rst_wre", 32'(mem_wre), 32'd0);
      chk("rst_ce", 32'(mem_ce), 32'd1);
      chk("rst_din", 32'(mem_din), 32'd0);
      chk("rst_busy", 32'(load_busy), 32'd0);
      chk("rst_err", 32'(load_err), 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);
      chk("rst_ad_mux", 32'(mem_ad), 32'h123);
      rst_n = 1'b1;
      @(negedge clk);
      cpu_adr = 11'h055;
      #1;
      chk("ad_follows_cpu", 32'(mem_ad), 32'h055);
      @(negedge clk);

      // Noise in RUN
      send_byte(8'h00);
      send_byte(8'h5A);
      send_byte(8'hFF);
      chk("noise_run", 32'(cpu_run), 32'd1);
      chk("noise_busy", 32'(load_busy), 32'd0);

      // Good 3-word load
      wr_snap = n_wr;
      send_frame(3, good_csum);
      chk("good_run", 32'(cpu_run), 32'd1);
      chk("good_busy", 32'(load_busy), 32'd0);
      chk("good_err", 32'(load_err), 32'd0);
      chk("good_words", 32'(words_loaded), 32'd3);
      chk("good_wr_count", 32'(n_wr - wr_snap), 32'd3);
      chk("good_ad_mux", 32'(mem_ad), 32'h055);

      // Bad checksum, then recovery
      wr_snap = n_wr;
      send_frame(3, 8'h00);
      chk("badcs_err", 32'(load_err), 32'd1);
      chk("badcs_run", 32'(cpu_run), 32'd0);
      chk("badcs_busy", 32'(load_busy), 32'd0);
      chk("badcs_words", 32'(words_loaded), 32'd3);
      chk("badcs_wr_count", 32'(n_wr - wr_snap), 32'd3);
      send_byte(8'h33);
      chk("err_ignores", 32'(load_err), 32'd1);
      send_frame(3, good_csum);
      chk("recover_err", 32'(load_err), 32'd0);
      chk("recover_run", 32'(cpu_run), 32'd1);

      // Bad lengths
      wr_snap = n_wr;
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h00);
      chk("len0_err", 32'(load_err), 32'd1);
      chk("len0_busy", 32'(load_busy), 32'd0);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h08);
      chk("len801_err", 32'(load_err), 32'd1);
      chk("len801_run", 32'(cpu_run), 32'd0);
      repeat (3) @(negedge clk);
      chk("badlen_no_wr", 32'(n_wr - wr_snap), 32'd0);

      // Max length accepted, then timeout after a lone low byte
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h08);
      chk("len800_busy", 32'(load_busy), 32'd1);
      chk("len800_err", 32'(load_err), 32'd0);
      send_word(16'hBEEF, 0);
      send_byte(8'h11);
      wr_snap = n_wr;
      repeat (90) @(negedge clk);
      chk("tmo_not_yet", 32'(load_err), 32'd0);
      repeat (20) @(negedge clk);
      chk("tmo_err", 32'(load_err), 32'd1);
      chk("tmo_run", 32'(cpu_run), 32'd0);
      chk("tmo_busy", 32'(load_busy), 32'd0);
      chk("tmo_no_wr", 32'(n_wr - wr_snap), 32'd0);

      // Reset in the middle of the data phase
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_word(prog[0], 0);
      send_byte(8'h78);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_run", 32'(cpu_run), 32'd1);
      chk("mid_rst_busy", 32'(load_busy), 32'd0);
      chk("mid_rst_err", 32'(load_err), 32'd0);
      chk("mid_rst_words", 32'(words_loaded), 32'd0);
      chk("mid_rst_wre", 32'(mem_wre), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_byte(8'h00);
      chk("post_rst_run", 32'(cpu_run), 32'd1);
      chk("post_rst_busy", 32'(load_busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
